// File: rtl/pulse_train_generator_if.sv
// Command/status bundle for the pulse-train generator.
// The generator sits on the slave side; whoever issues commands uses master.
interface pulse_train_generator_if #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [LEN_W-1:0] high_len;
    logic [LEN_W-1:0] low_len;
    logic [CNT_W-1:0] num_pulses;
    logic             ready;
    logic             pulse;
    logic             done;

    modport master (
        output start, high_len, low_len, num_pulses,
        input  ready, pulse, done
    );

    modport slave (
        input  start, high_len, low_len, num_pulses,
        output ready, pulse, done
    );
endinterface

// File: rtl/pulse_train_generator.sv
// Emits N high pulses of programmable width and gap on a registered output,
// then a one-cycle done strobe.
//
//   state  | meaning
//   S_IDLE | ready for a command, outputs low
//   S_HIGH | pulse high, high counter running
//   S_LOW  | gap between pulses, low counter running
//   S_DONE | one-cycle completion strobe
module pulse_train_generator #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    pulse_train_generator_if.slave  bus_s
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] h_len_q, h_len_d;
    logic [LEN_W-1:0] l_len_q, l_len_d;
    logic [LEN_W-1:0] h_cnt_q, h_cnt_d;
    logic [LEN_W-1:0] l_cnt_q, l_cnt_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic             pulse_q, pulse_d;
    logic             done_q,  done_d;

    // Zero lengths become one so successive pulses always stay distinct.
    function automatic logic [LEN_W-1:0] clamp1(input logic [LEN_W-1:0] v);
        return (v == '0) ? LEN_W'(1) : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            h_len_q <= '0;
            l_len_q <= '0;
            h_cnt_q <= '0;
            l_cnt_q <= '0;
            rem_q   <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_len_q <= h_len_d;
            l_len_q <= l_len_d;
            h_cnt_q <= h_cnt_d;
            l_cnt_q <= l_cnt_d;
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_len_d = h_len_q;
        l_len_d = l_len_q;
        h_cnt_d = h_cnt_q;
        l_cnt_d = l_cnt_q;
        rem_d   = rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus_s.start) begin
                    h_len_d = clamp1(bus_s.high_len);
                    l_len_d = clamp1(bus_s.low_len);
                    rem_d   = bus_s.num_pulses;
                    if (bus_s.num_pulses == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HIGH;
                        h_cnt_d = clamp1(bus_s.high_len);
                    end
                end
            end
            S_HIGH: begin
                if (h_cnt_q == LEN_W'(1)) begin
                    h_cnt_d = '0;
                    rem_d   = rem_q - CNT_W'(1);
                    // The last pulse goes straight to DONE with no trailing gap.
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOW;
                        l_cnt_d = l_len_q;
                    end
                end else begin
                    h_cnt_d = h_cnt_q - LEN_W'(1);
                end
            end
            S_LOW: begin
                if (l_cnt_q == LEN_W'(1)) begin
                    l_cnt_d = '0;
                    state_d = S_HIGH;
                    h_cnt_d = h_len_q;
                end else begin
                    l_cnt_d = l_cnt_q - LEN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered decodes of the next state, so they line up with state_q.
    always_comb begin
        pulse_d = (state_d == S_HIGH);
        done_d  = (state_d == S_DONE);
    end

    assign bus_s.pulse = pulse_q;
    assign bus_s.done  = done_q;
    assign bus_s.ready = (state_q == S_IDLE);

endmodule
